// File: rtl/dtype_seq_gen_n_if.sv
// Control and result bus between the button-memory front end and the sequence generator.
// The master drives mode/run/step/load; the generator (slave) returns the sequence and status.
interface dtype_seq_gen_n_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             run;
    logic             step;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] result;
    logic             tick;
    logic             wrap;
    logic             running;

    modport master (
        output mode, run, step, load, load_value,
        input  result, tick, wrap, running
    );

    modport slave (
        input  mode, run, step, load, load_value,
        output result, tick, wrap, running
    );
endinterface

// File: rtl/dtype_seq_gen_n.sv
// WIDTH-bit sequence generator (binary up/down, Johnson, Gray) advanced by a prescaled
// tick while running or by a single step while stopped; start value is loadable.
module dtype_seq_gen_n #(
    parameter int WIDTH = 4,
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    dtype_seq_gen_n_if.slave bus
);
    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [DIV_W-1:0]   r_presc;
    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_tick;
    logic               r_wrap;
    logic               w_tick_evt;
    logic               w_advance;
    logic [WIDTH-1:0]   w_cnt_next;
    logic [WIDTH-1:0]   w_johnson;
    logic [WIDTH-1:0]   w_gray;
    logic               w_wrap_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A tick in the same cycle run drops still advances; the stop takes effect afterwards.
    always_comb begin
        w_state_next = r_state;
        w_tick_evt   = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                w_advance = bus.step;
                if (bus.run) begin
                    w_state_next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                w_tick_evt = (r_presc == PRESC_LAST);
                w_advance  = w_tick_evt;
                if (!bus.run) begin
                    w_state_next = ST_STOPPED;
                end
            end
            default: w_state_next = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (bus.load || r_state != ST_RUNNING || w_state_next != ST_RUNNING) begin
            r_presc <= '0;
        end else if (w_tick_evt) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    assign w_johnson = {r_cnt[WIDTH-2:0], ~r_cnt[WIDTH-1]};

    always_comb begin
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (bus.load) begin
            w_cnt_next = bus.load_value;
        end else if (w_advance) begin
            case (bus.mode)
                2'b01: begin
                    w_cnt_next  = r_cnt - CNT_ONE;
                    w_wrap_next = ~|r_cnt;
                end
                2'b10: begin
                    w_cnt_next  = w_johnson;
                    w_wrap_next = ~|w_johnson;
                end
                default: begin
                    w_cnt_next  = r_cnt + CNT_ONE;
                    w_wrap_next = &r_cnt;
                end
            endcase
        end
    end

    // Gray output is recoded from the next count so a mode change shows up one cycle later.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign w_gray[gi] = w_cnt_next[gi] ^ w_cnt_next[gi+1];
        end
    endgenerate
    assign w_gray[WIDTH-1] = w_cnt_next[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_result <= (bus.mode == 2'b11) ? w_gray : w_cnt_next;
            r_tick   <= w_tick_evt;
            r_wrap   <= w_wrap_next;
        end
    end

    assign bus.result  = r_result;
    assign bus.tick    = r_tick;
    assign bus.wrap    = r_wrap;
    assign bus.running = (r_state == ST_RUNNING);

endmodule

// File: tb/tb_dtype_seq_gen_n.sv
// Bench for dtype_seq_gen_n (WIDTH=4, DIV=4): cycle-by-cycle reference model plus directed
// scenarios with literal expectations for each mode and the collision cases.
module tb_dtype_seq_gen_n;
    localparam int W    = 4;
    localparam int DIV  = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    dtype_seq_gen_n_if #(.WIDTH(W)) bif ();

    dtype_seq_gen_n #(.WIDTH(W), .DIV(DIV), .DIV_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count as a plain integer, prescaler as a modulo-DIV phase.
    int m_cnt, m_presc, e_result, e_tick, e_wrap, e_running;
    bit m_run_st, tk, adv;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cnt = 0; m_presc = 0; m_run_st = 0;
                e_result = 0; e_tick = 0; e_wrap = 0; e_running = 0;
            end else begin
                tk  = m_run_st && (m_presc == DIV - 1);
                adv = m_run_st ? tk : bif.step;
                e_tick = tk;
                e_wrap = 0;
                if (bif.load) begin
                    m_cnt = int'(bif.load_value);
                end else if (adv) begin
                    case (bif.mode)
                        2'd1: begin
                            e_wrap = (m_cnt == 0);
                            m_cnt  = (m_cnt + MAXV) % (MAXV + 1);
                        end
                        2'd2: begin
                            m_cnt  = (m_cnt * 2 + ((m_cnt < HALF) ? 1 : 0)) % (MAXV + 1);
                            e_wrap = (m_cnt == 0);
                        end
                        default: begin
                            e_wrap = (m_cnt == MAXV);
                            m_cnt  = (m_cnt + 1) % (MAXV + 1);
                        end
                    endcase
                end
                m_presc   = (bif.load || !m_run_st || !bif.run) ? 0 : (m_presc + 1) % DIV;
                m_run_st  = bif.run;
                e_running = bif.run;
                e_result  = (bif.mode == 2'd3) ? (m_cnt ^ (m_cnt / 2)) : m_cnt;
            end
            #1;
            chk("m_result",  int'(bif.result),  e_result);
            chk("m_tick",    int'(bif.tick),    e_tick);
            chk("m_wrap",    int'(bif.wrap),    e_wrap);
            chk("m_running", int'(bif.running), e_running);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_step();
        bif.step = 1'b1;
        cyc();
        bif.step = 1'b0;
    endtask

    int n_tick, n_wrap, prev;
    int down_exp[5]  = '{2, 1, 0, 15, 14};
    int john_exp[8]  = '{1, 3, 7, 15, 14, 12, 8, 0};
    int gray_exp[8]  = '{1, 3, 2, 6, 7, 5, 4, 12};
    bit found;

    initial begin
        reset = 1'b1;
        bif.mode = 2'd0; bif.run = 1'b1; bif.step = 1'b0;
        bif.load = 1'b0; bif.load_value = '0;
        cyc(); cyc();
        chk("rst_result",  int'(bif.result),  0);
        chk("rst_tick",    int'(bif.tick),    0);
        chk("rst_running", int'(bif.running), 0);

        // Up mode free-run
        reset = 1'b0;
        n_tick = 0; n_wrap = 0;
        for (int i = 0; i < 70; i++) begin
            cyc();
            if (i == 0) chk("run_after_release", int'(bif.running), 1);
            n_tick += int'(bif.tick);
            n_wrap += int'(bif.wrap);
        end
        chk("up_ticks", n_tick, 17);
        chk("up_wraps", n_wrap, 1);
        chk("up_result", int'(bif.result), 1);
        bif.run = 1'b0;
        cyc();
        chk("stop_running", int'(bif.running), 0);

        // Down mode with load and single steps
        bif.mode = 2'd1; bif.load_value = 4'd3; bif.load = 1'b1;
        cyc();
        bif.load = 1'b0;
        chk("down_load", int'(bif.result), 3);
        for (int i = 0; i < 5; i++) begin
            do_step();
            chk("down_result", int'(bif.result), down_exp[i]);
            chk("down_wrap",   int'(bif.wrap), (i == 3) ? 1 : 0);
            chk("down_tick",   int'(bif.tick), 0);
            cyc();
        end

        // Johnson from reset
        reset = 1'b1; cyc(); reset = 1'b0;
        bif.mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            do_step();
            chk("john_result", int'(bif.result), john_exp[i]);
            chk("john_wrap",   int'(bif.wrap), (i == 7) ? 1 : 0);
        end

        // Gray from reset, then switch back to binary to see the raw count
        reset = 1'b1; cyc(); reset = 1'b0;
        bif.mode = 2'd3;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            do_step();
            chk("gray_result", int'(bif.result), gray_exp[i]);
            chk("gray_onebit", $countones(bif.result ^ 4'(prev)), 1);
            prev = int'(bif.result);
        end
        bif.mode = 2'd0;
        cyc();
        chk("gray_recode", int'(bif.result), 8);

        // Load colliding with a tick
        reset = 1'b1; cyc(); reset = 1'b0;
        bif.run = 1'b1;
        repeat (4) cyc();
        bif.load = 1'b1; bif.load_value = 4'd9;
        cyc();
        bif.load = 1'b0;
        chk("coll_result", int'(bif.result), 9);
        chk("coll_wrap",   int'(bif.wrap), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("coll_restart_tick", int'(bif.tick), 0);
        end
        cyc();
        chk("coll_next_tick",   int'(bif.tick), 1);
        chk("coll_next_result", int'(bif.result), 10);

        // Reset mid-run once the sequence reaches 6
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (bif.result == 4'd6) found = 1'b1;
        end
        chk("reach_6_timeout", int'(found), 1);
        reset = 1'b1;
        cyc();
        chk("midrst_result",  int'(bif.result), 0);
        chk("midrst_running", int'(bif.running), 0);
        reset = 1'b0;
        cyc();
        chk("resume_running", int'(bif.running), 1);

        // run drops in the same cycle as the tick: advance still happens
        repeat (3) cyc();
        bif.run = 1'b0;
        cyc();
        chk("drop_result",  int'(bif.result), 1);
        chk("drop_tick",    int'(bif.tick), 1);
        chk("drop_running", int'(bif.running), 0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dtype_seq_gen_n.md
Name: dtype_seq_gen_n

Overview:
- Parametrised, multi-mode successor to the fixed 4-bit D-type sequence generators that drive the LED/LCD result bus.
- Generates a WIDTH-bit sequence in one of four modes: binary up, binary down, Johnson, or Gray.
- Advances either on a prescaled tick while running, or on a single-step request.
- Supports synchronous load of a start value from the button-memory operands.
- Sits between BTN_memory and the LED/LCD display logic.

Parameters:
- WIDTH, 4, sequence/result width in bits; legal range 2..16.
- DIV, 25000000, prescaler terminal count; one tick every DIV clk cycles; minimum 2.
- DIV_W, 25, prescaler counter width; must satisfy 2^DIV_W >= DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  00 binary up, 01 binary down, 10 Johnson, 11 Gray up.
- run  input  1  level; 1 = free-run on prescaler ticks.
- step  input  1  single-cycle pulse; advances one step when not running.
- load  input  1  single-cycle pulse; loads load_value.
- load_value  input  WIDTH  start value for binary/Gray modes and raw state for Johnson.
- result  output  WIDTH  current sequence value (registered).
- tick  output  1  one-cycle pulse on each prescaler terminal count while RUNNING.
- wrap  output  1  one-cycle pulse coincident with the advance that completes a cycle.
- running  output  1  1 when the FSM is in RUNNING.

Behaviour:
- Reset (synchronous, when reset=1 at an edge):
  - state=STOPPED; internal count=0; prescaler=0.
  - result=0, tick=0, wrap=0, running=0.
  - reset has priority over every other input.
- FSM:
  - STOPPED -> RUNNING when run=1.
  - RUNNING -> STOPPED when run=0.
  - running mirrors the state, one cycle after the run change.
- Prescaler:
  - Counts only in RUNNING.
  - At count DIV-1: wraps to 0 and asserts tick for one cycle.
  - Cleared to 0 on entry to STOPPED and on load.
- Advance event:
  - In RUNNING, each tick is an advance.
  - In STOPPED, step=1 is an advance.
  - step is ignored while RUNNING.
- Priority: reset > load > advance.
  - load=1 sets the count to load_value the next cycle and suppresses any same-cycle advance; wrap=0.
- Internal register cnt[WIDTH-1:0]; result = cnt, except in Gray mode, where result = cnt ^ (cnt >> 1).
- Update of cnt on advance, by mode:
  - Up: cnt+1 modulo 2^WIDTH. wrap=1 when cnt was all-ones.
  - Down: cnt-1 modulo 2^WIDTH. wrap=1 when cnt was 0.
  - Johnson: cnt = {cnt[WIDTH-2:0], ~cnt[WIDTH-1]}. wrap=1 when the new cnt is 0. Period is 2*WIDTH from 0.
  - Gray: same as Up on cnt. wrap=1 when cnt was all-ones.
- Latency:
  - result changes in the cycle after the advance or load edge.
  - wrap is registered with the same timing as the result change.
- Mode change takes effect at the next advance; cnt is not altered by the change. In Gray mode the output recodes immediately, one cycle after the mode change (registered).
- Johnson entered from a non-Johnson value: shifting follows the rule above. Illegal patterns are not corrected; the first load or reset restores a legal sequence.
- run dropping in the same cycle as tick: the advance still occurs, then the FSM enters STOPPED.
- reset asserted mid-run: all outputs are 0 the next cycle; the FSM resumes only when run=1 is sampled after reset deasserts.

Test Plan:
- Reset check (WIDTH=4, DIV=4): reset=1 for 2 cycles with run=1 -> result=0, tick=0, running=0. After release, running=1 one cycle later.
- Up mode (DIV=4): run=1 for 70 cycles -> tick every 4th cycle; result steps 0,1,2..15,0; wrap pulses exactly once, on the 15->0 transition.
- Down mode with load: load_value=3, load=1, then step pulsed 5 times while stopped -> result 3,2,1,0,15,14; wrap on the 0->15 transition; no tick pulses.
- Johnson mode: from reset, 8 steps -> result 0001,0011,0111,1111,1110,1100,1000,0000; wrap on the 8th step only.
- Gray mode (WIDTH=3): 8 steps -> result 001,011,010,110,111,101,100,000; each transition changes exactly one bit.
- Collision cases:
  - load and tick in the same cycle with load_value=9 -> result=9, wrap=0, prescaler restarts.
  - reset mid-run at result=6 -> result=0 the next cycle.
